// File: rtl/noc_inject_arbiter_pkg.sv
// Shared NoC constants, arbiter FSM encodings and the output-stage record.
// Stands in for Noc_parameters.v so that every file of the slice sees one definition.
package noc_inject_arbiter_pkg;

  localparam int Noc_Data_Width  = 32;
  localparam int Noc_ID_X_Width  = 4;
  localparam int Noc_ID_Y_Width  = 4;
  localparam int Noc_Arb_Max_Req = 8;

  localparam logic [0:0] ARB_IDLE   = 1'b0;
  localparam logic [0:0] ARB_LOCKED = 1'b1;

  typedef struct packed {
    logic                      valid;
    logic                      is_header;
    logic                      is_tail;
    logic [Noc_Data_Width-1:0] flit;
  } out_stage_t;

endpackage

// File: rtl/noc_inject_arbiter_rr_picker.sv
// Combinational round-robin picker: first set request at or above rr_ptr_i, wrapping.
// Produces one-hot and binary forms of the winner plus an any-request flag.
module noc_rr_picker #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   rr_ptr_i,
  output logic [NUM_REQ-1:0] grant_oh_o,
  output logic [IDX_W-1:0]   grant_idx_o,
  output logic               any_o
);

  logic [NUM_REQ-1:0] rot;
  logic [IDX_W-1:0]   rot_idx [NUM_REQ];

  // rot[k] is the request k places after the pointer, so priority is simply k ascending.
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_rot
    logic [IDX_W:0] sum;
    assign sum         = {1'b0, rr_ptr_i} + (IDX_W+1)'(gi);
    assign rot_idx[gi] = (sum >= (IDX_W+1)'(NUM_REQ)) ? IDX_W'(sum - (IDX_W+1)'(NUM_REQ))
                                                      : sum[IDX_W-1:0];
    assign rot[gi]     = req_i[rot_idx[gi]];
  end

  always_comb begin
    any_o       = 1'b0;
    grant_idx_o = '0;
    grant_oh_o  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!any_o && rot[k]) begin
        any_o       = 1'b1;
        grant_idx_o = rot_idx[k];
      end
    end
    if (any_o) grant_oh_o[grant_idx_o] = 1'b1;
  end

endmodule

// File: rtl/noc_inject_arbiter.sv
// Packet-level round-robin arbiter for a NoC injection port: grants on header,
// locks to the winner until its tail, and drives the router through one register stage.
module noc_inject_arbiter
  import noc_inject_arbiter_pkg::*;
#(
  parameter int                        NUM_REQ   = 4,
  parameter int                        REQ_IDX_W = 2,
  parameter logic [Noc_ID_X_Width-1:0] X_ID      = '0,
  parameter logic [Noc_ID_Y_Width-1:0] Y_ID      = '0
) (
  input  logic                              noc_clk,
  input  logic                              noc_rst,
  input  logic [NUM_REQ-1:0]                cfg_port_en,
  input  logic [NUM_REQ-1:0]                req_valid,
  output logic [NUM_REQ-1:0]                req_ready,
  input  logic [NUM_REQ*Noc_Data_Width-1:0] req_flit,
  input  logic [NUM_REQ-1:0]                req_is_header,
  input  logic [NUM_REQ-1:0]                req_is_tail,
  output logic                              sender_valid,
  input  logic                              sender_ready,
  output logic [Noc_Data_Width-1:0]         sender_flit,
  output logic                              sender_is_header,
  output logic                              sender_is_tail,
  output logic [REQ_IDX_W-1:0]              grant_id,
  output logic                              busy,
  output logic                              err_orphan
);

  if (NUM_REQ < 2 || NUM_REQ > Noc_Arb_Max_Req || REQ_IDX_W != $clog2(NUM_REQ)) begin : g_bad_cfg
    $error("noc_inject_arbiter (%0d,%0d): unsupported NUM_REQ/REQ_IDX_W", X_ID, Y_ID);
  end

  logic [0:0]           state_q, state_d;
  logic [REQ_IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [REQ_IDX_W-1:0] grant_q, grant_d;
  logic                 err_q, err_d;
  out_stage_t           out_q, out_d;

  logic                 out_ok;
  logic [NUM_REQ-1:0]   cand;
  logic [NUM_REQ-1:0]   orphan;
  logic [NUM_REQ-1:0]   ready_vec;
  logic [NUM_REQ-1:0]   pick_oh;
  logic [REQ_IDX_W-1:0] pick_idx;
  logic                 pick_any;
  logic                 load;
  logic [REQ_IDX_W-1:0] load_idx;

  function automatic logic [REQ_IDX_W-1:0] ptr_inc(input logic [REQ_IDX_W-1:0] idx);
    if (int'(idx) >= NUM_REQ - 1) return '0;
    return idx + 1'b1;
  endfunction

  assign out_ok = ~out_q.valid | sender_ready;

  // Readys are forced low while reset is held so nothing is consumed during reset.
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_port
    assign cand[gi]      = req_valid[gi] &  req_is_header[gi] & cfg_port_en[gi];
    assign orphan[gi]    = req_valid[gi] & ~req_is_header[gi] & cfg_port_en[gi];
    assign req_ready[gi] = ready_vec[gi] & ~noc_rst;
  end

  noc_rr_picker #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (REQ_IDX_W)
  ) u_picker (
    .req_i       (cand),
    .rr_ptr_i    (rr_ptr_q),
    .grant_oh_o  (pick_oh),
    .grant_idx_o (pick_idx),
    .any_o       (pick_any)
  );

  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    grant_d   = grant_q;
    err_d     = err_q;
    ready_vec = '0;
    load      = 1'b0;
    load_idx  = grant_q;
    if (state_q == ARB_IDLE) begin
      if (|orphan) err_d = 1'b1;
      if (pick_any && out_ok) begin
        ready_vec = pick_oh;
        load      = 1'b1;
        load_idx  = pick_idx;
        grant_d   = pick_idx;
        // A single-flit packet completes at grant, so the lock is skipped entirely.
        if (req_is_tail[pick_idx]) rr_ptr_d = ptr_inc(pick_idx);
        else                       state_d  = ARB_LOCKED;
      end
    end else begin
      ready_vec[grant_q] = out_ok;
      if (out_ok && req_valid[grant_q]) begin
        load = 1'b1;
        if (req_is_tail[grant_q]) begin
          state_d  = ARB_IDLE;
          rr_ptr_d = ptr_inc(grant_q);
        end
      end
    end
  end

  always_comb begin
    out_d = out_q;
    if (load) begin
      out_d.valid     = 1'b1;
      out_d.is_header = req_is_header[load_idx];
      out_d.is_tail   = req_is_tail[load_idx];
      out_d.flit      = req_flit[int'(load_idx)*Noc_Data_Width +: Noc_Data_Width];
    end else if (sender_ready) begin
      out_d.valid = 1'b0;
    end
  end

  always_ff @(posedge noc_clk or posedge noc_rst) begin
    if (noc_rst) begin
      state_q  <= ARB_IDLE;
      rr_ptr_q <= '0;
      grant_q  <= '0;
      err_q    <= 1'b0;
      out_q    <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      grant_q  <= grant_d;
      err_q    <= err_d;
      out_q    <= out_d;
    end
  end

  assign sender_valid     = out_q.valid;
  assign sender_flit      = out_q.flit;
  assign sender_is_header = out_q.is_header;
  assign sender_is_tail   = out_q.is_tail;
  assign grant_id         = grant_q;
  assign busy             = (state_q == ARB_LOCKED);
  assign err_orphan       = err_q;

endmodule

// File: tb/tb_noc_inject_arbiter.sv
// Scenario bench for noc_inject_arbiter: per-port source queues feed the DUT and an
// expected-flit queue is checked against every flit the router side takes.
module tb_noc_inject_arbiter;
  import noc_inject_arbiter_pkg::*;

  localparam int N = 4;
  localparam int W = Noc_Data_Width;

  typedef struct packed {
    logic         hdr;
    logic         tail;
    logic [W-1:0] data;
  } flit_t;

  logic           noc_clk = 1'b0;
  logic           noc_rst;
  logic [N-1:0]   cfg_port_en;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_ready;
  logic [N*W-1:0] req_flit;
  logic [N-1:0]   req_is_header;
  logic [N-1:0]   req_is_tail;
  logic           sender_valid;
  logic           sender_ready;
  logic [W-1:0]   sender_flit;
  logic           sender_is_header;
  logic           sender_is_tail;
  logic [1:0]     grant_id;
  logic           busy;
  logic           err_orphan;

  always #5 noc_clk = ~noc_clk;

  noc_inject_arbiter #(.NUM_REQ(N), .REQ_IDX_W(2), .X_ID(4'd0), .Y_ID(4'd0)) dut (
    .noc_clk          (noc_clk),
    .noc_rst          (noc_rst),
    .cfg_port_en      (cfg_port_en),
    .req_valid        (req_valid),
    .req_ready        (req_ready),
    .req_flit         (req_flit),
    .req_is_header    (req_is_header),
    .req_is_tail      (req_is_tail),
    .sender_valid     (sender_valid),
    .sender_ready     (sender_ready),
    .sender_flit      (sender_flit),
    .sender_is_header (sender_is_header),
    .sender_is_tail   (sender_is_tail),
    .grant_id         (grant_id),
    .busy             (busy),
    .err_orphan       (err_orphan)
  );

  flit_t src_q [N][$];
  flit_t exp_q [$];
  int    tests_run    = 0;
  int    tests_failed = 0;

  logic         s_valid, s_hdr, s_tail, s_fire, s_busy, s_err;
  logic [W-1:0] s_flit;
  logic [1:0]   s_grant;
  logic [N-1:0] s_ready, s_acc;
  flit_t        got, want;

  function automatic flit_t mk(input logic h, input logic t, input logic [W-1:0] d);
    return {h, t, d};
  endfunction

  task automatic drive_inputs();
    for (int i = 0; i < N; i++) begin
      if (src_q[i].size() > 0) begin
        req_valid[i]          = 1'b1;
        req_is_header[i]      = src_q[i][0].hdr;
        req_is_tail[i]        = src_q[i][0].tail;
        req_flit[i*W +: W]    = src_q[i][0].data;
      end else begin
        req_valid[i]          = 1'b0;
        req_is_header[i]      = 1'b0;
        req_is_tail[i]        = 1'b0;
        req_flit[i*W +: W]    = '0;
      end
    end
  endtask

  // One clock: drive sources, sample everything at the falling edge, retire accepted flits.
  task automatic cycle();
    drive_inputs();
    @(negedge noc_clk);
    s_valid = sender_valid;
    s_hdr   = sender_is_header;
    s_tail  = sender_is_tail;
    s_flit  = sender_flit;
    s_fire  = sender_valid & sender_ready;
    s_busy  = busy;
    s_err   = err_orphan;
    s_grant = grant_id;
    s_ready = req_ready;
    s_acc   = req_valid & req_ready;
    got     = {s_hdr, s_tail, s_flit};
    @(posedge noc_clk);
    #1;
    for (int i = 0; i < N; i++) if (s_acc[i]) src_q[i].delete(0);
  endtask

  task automatic do_reset();
    noc_rst      = 1'b1;
    sender_ready = 1'b1;
    cfg_port_en  = '1;
    for (int i = 0; i < N; i++) src_q[i].delete();
    exp_q.delete();
    drive_inputs();
    repeat (2) @(posedge noc_clk);
    #1 noc_rst = 1'b0;
  endtask

  task automatic test_reset();
    noc_rst      = 1'b1;
    sender_ready = 1'b1;
    cfg_port_en  = '1;
    src_q[0].push_back(mk(1'b1, 1'b0, 32'hA0));
    drive_inputs();
    #2;
    tests_run++; if (sender_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_valid: got %b, required 0", sender_valid); end
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %b, required 0", busy); end
    tests_run++; if (grant_id !== 2'd0) begin tests_failed++; $display("FAIL reset_grant: got %0d, required 0", grant_id); end
    tests_run++; if (err_orphan !== 1'b0) begin tests_failed++; $display("FAIL reset_err: got %b, required 0", err_orphan); end
    tests_run++; if (req_ready !== 4'b0000) begin tests_failed++; $display("FAIL reset_ready: got %b, required 0000", req_ready); end
    $display("[TB] reset state checked");
    do_reset();
  endtask

  task automatic test_single();
    int busy_cnt = 0;
    int first = -1;
    int last = -1;
    do_reset();
    src_q[0].push_back(mk(1'b1, 1'b0, 32'hA1));
    src_q[0].push_back(mk(1'b0, 1'b0, 32'hA2));
    src_q[0].push_back(mk(1'b0, 1'b1, 32'hA3));
    exp_q.push_back(mk(1'b1, 1'b0, 32'hA1));
    exp_q.push_back(mk(1'b0, 1'b0, 32'hA2));
    exp_q.push_back(mk(1'b0, 1'b1, 32'hA3));
    for (int k = 0; k < 8; k++) begin
      cycle();
      if (s_busy) busy_cnt++;
      if (s_fire) begin
        if (first < 0) first = k;
        last = k;
        tests_run++;
        if (exp_q.size() == 0) begin tests_failed++; $display("FAIL single_extra: got %h, required no flit", got); end
        else begin
          want = exp_q.pop_front();
          if (got !== want) begin tests_failed++; $display("FAIL single_flit: got %h, required %h", got, want); end
        end
        $display("[TB] single out hdr=%0b tail=%0b data=%h", s_hdr, s_tail, s_flit);
      end
    end
    tests_run++; if (busy_cnt != 2) begin tests_failed++; $display("FAIL single_busy: got %0d cycles, required 2", busy_cnt); end
    tests_run++; if (last - first != 2) begin tests_failed++; $display("FAIL single_spacing: got %0d, required 2", last - first); end
    tests_run++; if (s_grant !== 2'd0) begin tests_failed++; $display("FAIL single_grant: got %0d, required 0", s_grant); end
    tests_run++; if (exp_q.size() != 0) begin tests_failed++; $display("FAIL single_missing: got %0d left, required 0", exp_q.size()); end
    // Pointer now sits at 1, so port 1 must beat port 0 on a simultaneous request.
    src_q[0].push_back(mk(1'b1, 1'b1, 32'hB0));
    src_q[1].push_back(mk(1'b1, 1'b1, 32'hB1));
    exp_q.push_back(mk(1'b1, 1'b1, 32'hB1));
    exp_q.push_back(mk(1'b1, 1'b1, 32'hB0));
    for (int k = 0; k < 5; k++) begin
      cycle();
      if (s_fire) begin
        tests_run++;
        if (exp_q.size() == 0) begin tests_failed++; $display("FAIL rrptr_extra: got %h, required no flit", got); end
        else begin
          want = exp_q.pop_front();
          if (got !== want) begin tests_failed++; $display("FAIL rrptr_order: got %h, required %h", got, want); end
        end
        $display("[TB] rrptr out data=%h", s_flit);
      end
    end
    tests_run++; if (exp_q.size() != 0) begin tests_failed++; $display("FAIL rrptr_missing: got %0d left, required 0", exp_q.size()); end
  endtask

  task automatic test_fairness();
    int first = -1;
    int last = -1;
    int nfire = 0;
    do_reset();
    for (int r = 0; r < 3; r++) begin
      for (int p = 0; p < N; p++) begin
        src_q[p].push_back(mk(1'b1, 1'b1, 32'(32'h100 * p + r)));
        exp_q.push_back(mk(1'b1, 1'b1, 32'(32'h100 * p + r)));
      end
    end
    for (int k = 0; k < 16; k++) begin
      cycle();
      if (s_fire) begin
        if (first < 0) first = k;
        last = k;
        nfire++;
        tests_run++;
        if (exp_q.size() == 0) begin tests_failed++; $display("FAIL fair_extra: got %h, required no flit", got); end
        else begin
          want = exp_q.pop_front();
          if (got !== want) begin tests_failed++; $display("FAIL fair_order: got %h, required %h", got, want); end
        end
        $display("[TB] fair out data=%h", s_flit);
      end
    end
    tests_run++; if (nfire != 12 || last - first != 11) begin tests_failed++; $display("FAIL fair_rate: got %0d flits over %0d cycles, required 12 over 11", nfire, last - first); end
    tests_run++; if (exp_q.size() != 0) begin tests_failed++; $display("FAIL fair_missing: got %0d left, required 0", exp_q.size()); end
  endtask

  task automatic test_lock();
    do_reset();
    src_q[1].push_back(mk(1'b1, 1'b0, 32'h11));
    src_q[1].push_back(mk(1'b0, 1'b0, 32'h12));
    src_q[1].push_back(mk(1'b1, 1'b0, 32'h13));
    src_q[1].push_back(mk(1'b0, 1'b1, 32'h14));
    exp_q.push_back(mk(1'b1, 1'b0, 32'h11));
    exp_q.push_back(mk(1'b0, 1'b0, 32'h12));
    exp_q.push_back(mk(1'b1, 1'b0, 32'h13));
    exp_q.push_back(mk(1'b0, 1'b1, 32'h14));
    exp_q.push_back(mk(1'b1, 1'b1, 32'h21));
    for (int k = 0; k < 10; k++) begin
      if (k == 1) src_q[2].push_back(mk(1'b1, 1'b1, 32'h21));
      cycle();
      tests_run++;
      if (s_ready[2] !== (k == 4)) begin tests_failed++; $display("FAIL lock_ready2 cyc%0d: got %b, required %b", k, s_ready[2], (k == 4)); end
      if (s_fire) begin
        tests_run++;
        if (exp_q.size() == 0) begin tests_failed++; $display("FAIL lock_extra: got %h, required no flit", got); end
        else begin
          want = exp_q.pop_front();
          if (got !== want) begin tests_failed++; $display("FAIL lock_order: got %h, required %h", got, want); end
        end
        $display("[TB] lock out hdr=%0b tail=%0b data=%h", s_hdr, s_tail, s_flit);
      end
    end
    tests_run++; if (exp_q.size() != 0) begin tests_failed++; $display("FAIL lock_missing: got %0d left, required 0", exp_q.size()); end
  endtask

  task automatic test_backpressure();
    do_reset();
    for (int i = 1; i <= 5; i++) begin
      src_q[0].push_back(mk(i == 1, i == 5, 32'(32'hC0 + i)));
      exp_q.push_back(mk(i == 1, i == 5, 32'(32'hC0 + i)));
    end
    for (int k = 0; k < 14; k++) begin
      sender_ready = !(k >= 2 && k < 7);
      cycle();
      if (k >= 2 && k < 7) begin
        tests_run++;
        if (s_valid !== 1'b1 || s_flit !== 32'hC2) begin tests_failed++; $display("FAIL bp_hold cyc%0d: got v=%b %h, required v=1 c2", k, s_valid, s_flit); end
        tests_run++;
        if (s_ready !== 4'b0000) begin tests_failed++; $display("FAIL bp_ready cyc%0d: got %b, required 0000", k, s_ready); end
      end
      if (s_fire) begin
        tests_run++;
        if (exp_q.size() == 0) begin tests_failed++; $display("FAIL bp_extra: got %h, required no flit", got); end
        else begin
          want = exp_q.pop_front();
          if (got !== want) begin tests_failed++; $display("FAIL bp_order: got %h, required %h", got, want); end
        end
        $display("[TB] bp out data=%h", s_flit);
      end
    end
    tests_run++; if (exp_q.size() != 0) begin tests_failed++; $display("FAIL bp_missing: got %0d left, required 0", exp_q.size()); end
  endtask

  task automatic test_errors();
    do_reset();
    src_q[3].push_back(mk(1'b0, 1'b0, 32'h33));
    for (int k = 0; k < 3; k++) begin
      cycle();
      tests_run++;
      if (s_ready[3] !== 1'b0 || s_fire) begin tests_failed++; $display("FAIL orphan_ready cyc%0d: got ready=%b fire=%b, required 0 0", k, s_ready[3], s_fire); end
    end
    tests_run++; if (s_err !== 1'b1) begin tests_failed++; $display("FAIL orphan_err: got %b, required 1", s_err); end
    $display("[TB] orphan flag=%0b", s_err);
    src_q[3].delete();
    cfg_port_en = 4'b1011;
    src_q[2].push_back(mk(1'b1, 1'b1, 32'h44));
    for (int k = 0; k < 4; k++) begin
      cycle();
      tests_run++;
      if (s_ready[2] !== 1'b0 || s_fire) begin tests_failed++; $display("FAIL disabled_grant cyc%0d: got ready=%b fire=%b, required 0 0", k, s_ready[2], s_fire); end
    end
    tests_run++; if (s_err !== 1'b1) begin tests_failed++; $display("FAIL orphan_sticky: got %b, required 1", s_err); end
    $display("[TB] disabled port idle, flag=%0b", s_err);
    src_q[2].delete();
    cfg_port_en = '1;
  endtask

  task automatic test_reset_mid();
    do_reset();
    src_q[2].push_back(mk(1'b1, 1'b0, 32'h61));
    src_q[2].push_back(mk(1'b0, 1'b0, 32'h62));
    src_q[2].push_back(mk(1'b0, 1'b0, 32'h63));
    repeat (3) cycle();
    tests_run++;
    if (busy !== 1'b1 || grant_id !== 2'd2 || sender_valid !== 1'b1) begin
      tests_failed++; $display("FAIL midpkt_pre: got busy=%b grant=%0d v=%b, required 1 2 1", busy, grant_id, sender_valid);
    end
    #2 noc_rst = 1'b1;
    #1;
    tests_run++; if (sender_valid !== 1'b0) begin tests_failed++; $display("FAIL midrst_valid: got %b, required 0", sender_valid); end
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL midrst_busy: got %b, required 0", busy); end
    tests_run++; if (grant_id !== 2'd0) begin tests_failed++; $display("FAIL midrst_grant: got %0d, required 0", grant_id); end
    $display("[TB] async reset mid-packet applied");
    do_reset();
  endtask

  initial begin
    req_valid = '0; req_is_header = '0; req_is_tail = '0; req_flit = '0;
    test_reset();
    test_single();
    test_fairness();
    test_lock();
    test_backpressure();
    test_errors();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
